shared_down_counter_arb: RTL and testbench
==========================================

// Module: shared_down_counter_arb
// PURPOSE
//  Shares one WIDTH-bit synchronous down counter between two requesters.
//  Each requester supplies a start value and holds req. A round-robin arbiter
//  grants the counter, loads it and counts it to zero. The winner then gets a
//  one-cycle done pulse. Used as the timer/sequencer in front of the mod-16 counter datapath.
// PARAMETERS
//  WIDTH  4  counter width in bits; start values and cnt are WIDTH bits
// PORTS
//  clk    in   1      rising-edge clock, sole clock
//  rst    in   1      synchronous, active-high reset
//  req    in   2      req[i] held high by requester i until done[i] or abort
//  load0  in   WIDTH  start value for requester 0, sampled at grant
//  load1  in   WIDTH  start value for requester 1, sampled at grant
//  pause  in   1      freezes count while high (RUN only)
//  gnt    out  2      one-hot grant, registered; 00 when idle
//  busy   out  1      high in RUN and DONE states
//  cnt    out  WIDTH  current counter value, registered
//  done   out  2      done[i] one-cycle pulse when requester i's count finishes
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, gnt=00, busy=0, done=00, rr pointer=1 (req0 wins first).
//  All outputs are registered, and the reset value of every output is listed above.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   - req==00: stay; cnt holds 0.
//   - one req bit set: grant it.
//   - req==11: grant the requester not served last (pointer).
//   - On grant: cnt<=load of winner, gnt<=onehot(winner), busy<=1, ptr<=winner, go RUN.
//  RUN:
//   - req[winner]==0 (abort): go IDLE; gnt<=00, busy<=0, cnt<=0, no done.
//   - else if cnt==0: go DONE; done[winner]<=1 (pause ignored; terminal wins).
//   - else if pause: cnt holds.
//   - else: cnt<=cnt-1. Never wraps below 0.
//  DONE: done pulse high this cycle only; gnt still held. Next cycle go IDLE with
//   gnt<=00, busy<=0, done<=00. cnt stays 0.
//  Latency (no pause), with req first seen in IDLE at edge t:
//   - gnt/cnt=N visible after edge t; cnt reaches 0 after edge t+N.
//   - done high after edge t+N+1; IDLE after edge t+N+2.
//   - No back-to-back grant: re-arbitration takes one IDLE cycle.
//  Start value 0: one RUN cycle at cnt=0, then DONE.
//  Changes to load0/load1 after grant are ignored.
//  Changes to req of the non-granted requester are ignored until IDLE.
//  rst asserted mid-operation: next edge forces the reset values.
//   No done is issued; the pointer returns to 1.
//  Aborting after grant still updates the pointer; the aborter loses priority next time.
// TESTING
//  T1 reset: rst=1 two cycles with req=11 -> gnt=00, cnt=0, busy=0, done=00.
//  T2 single: req=01, load0=5 -> gnt=01; cnt 5,4,3,2,1,0; done=01 for exactly 1 cycle,
//     7 cycles after grant; then gnt=00.
//  T3 contention: req=11 held, load0=2, load1=3 -> req0 served first, then one idle cycle,
//     then req1 (cnt 3..0), then req0 again (round-robin alternation).
//  T4 pause: req=10, load1=4, pause high 3 cycles when cnt=2 -> cnt holds 2 for 3 cycles;
//     done is delayed by 3 cycles. Pause at cnt=0 still gives done next cycle.
//  T5 abort/edge: req0 dropped at cnt=3 -> gnt=00, cnt=0, no done.
//     load=0 -> done 2 cycles after grant. load=15 (WIDTH=4) -> no wrap.
//  T6 reset mid-RUN: rst at cnt=6 -> all outputs reset next edge; no done.
//     With req=11, req0 is granted first after rst drops.

Source files
------------

// File: rtl/shared_down_counter_arb_if.sv
// rtl/shared_down_counter_arb_if.sv - requester/counter bundle for the shared down counter arbiter
interface shared_down_counter_arb_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] load0;
    logic [WIDTH-1:0] load1;
    logic             pause;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       done;

    modport master (
        output req, load0, load1, pause,
        input  gnt, busy, cnt, done
    );

    modport slave (
        input  req, load0, load1, pause,
        output gnt, busy, cnt, done
    );
endinterface

// File: rtl/shared_down_counter_arb.sv
// rtl/shared_down_counter_arb.sv - round-robin shared WIDTH-bit down counter with per-requester done pulse
module shared_down_counter_arb #(
    parameter int WIDTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    shared_down_counter_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [1:0]       done_q, done_d;
    // ptr holds the index of the last requester granted; win is the current owner
    logic             ptr_q, ptr_d;
    logic             win_q, win_d;
    logic             pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= ZERO;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
            ptr_q   <= 1'b1;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done_d  = 2'b00;
        ptr_d   = ptr_q;
        win_d   = win_q;
        pick    = (bus.req == 2'b11) ? ~ptr_q : bus.req[1];

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    cnt_d   = pick ? bus.load1 : bus.load0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    ptr_d   = pick;
                    win_d   = pick;
                    state_d = RUN;
                end else begin
                    cnt_d = ZERO;
                end
            end
            RUN: begin
                // abort beats terminal count, terminal count beats pause
                if (!bus.req[win_q]) begin
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    cnt_d   = ZERO;
                    state_d = IDLE;
                end else if (cnt_q == ZERO) begin
                    done_d  = win_q ? 2'b10 : 2'b01;
                    state_d = DONE;
                end else if (!bus.pause) begin
                    cnt_d = cnt_q - ONE;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                cnt_d   = ZERO;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                cnt_d   = ZERO;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.cnt  = cnt_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_shared_down_counter_arb.sv
// tb/tb_shared_down_counter_arb.sv - directed self-checking bench for shared_down_counter_arb
module tb_shared_down_counter_arb;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shared_down_counter_arb_if #(.WIDTH(4)) bus ();

    shared_down_counter_arb #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] g, input logic [3:0] c,
                         input logic b, input logic [1:0] d);
        checks++;
        assert (bus.gnt === g) else begin
            errors++;
            $error("FAIL %s gnt observed=%b expected=%b", tag, bus.gnt, g);
        end
        checks++;
        assert (bus.cnt === c) else begin
            errors++;
            $error("FAIL %s cnt observed=%0d expected=%0d", tag, bus.cnt, c);
        end
        checks++;
        assert (bus.busy === b) else begin
            errors++;
            $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, b);
        end
        checks++;
        assert (bus.done === d) else begin
            errors++;
            $error("FAIL %s done observed=%b expected=%b", tag, bus.done, d);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.req   = 2'b11;
        bus.load0 = 4'd0;
        bus.load1 = 4'd0;
        bus.pause = 1'b0;

        // T1 reset with both requests high
        step();
        step();
        check("t1_reset", 2'b00, 4'd0, 1'b0, 2'b00);
        bus.req = 2'b00;
        rst     = 1'b0;
        step();
        check("t1_idle", 2'b00, 4'd0, 1'b0, 2'b00);

        // T2 single requester, load 5
        bus.req   = 2'b01;
        bus.load0 = 4'd5;
        step();
        check("t2_grant", 2'b01, 4'd5, 1'b1, 2'b00);
        bus.load0 = 4'd9;
        for (int k = 4; k >= 0; k--) begin
            step();
            check("t2_count", 2'b01, 4'(k), 1'b1, 2'b00);
        end
        step();
        check("t2_done", 2'b01, 4'd0, 1'b1, 2'b01);
        bus.req = 2'b00;
        step();
        check("t2_idle", 2'b00, 4'd0, 1'b0, 2'b00);

        // T3 contention after reset: req0, idle gap, req1, idle gap, req0
        rst = 1'b1;
        step();
        rst       = 1'b0;
        bus.req   = 2'b11;
        bus.load0 = 4'd2;
        bus.load1 = 4'd3;
        step();
        check("t3_g0", 2'b01, 4'd2, 1'b1, 2'b00);
        step();
        check("t3_c0a", 2'b01, 4'd1, 1'b1, 2'b00);
        step();
        check("t3_c0b", 2'b01, 4'd0, 1'b1, 2'b00);
        step();
        check("t3_done0", 2'b01, 4'd0, 1'b1, 2'b01);
        step();
        check("t3_gap0", 2'b00, 4'd0, 1'b0, 2'b00);
        step();
        check("t3_g1", 2'b10, 4'd3, 1'b1, 2'b00);
        for (int k = 2; k >= 0; k--) begin
            step();
            check("t3_c1", 2'b10, 4'(k), 1'b1, 2'b00);
        end
        step();
        check("t3_done1", 2'b10, 4'd0, 1'b1, 2'b10);
        step();
        check("t3_gap1", 2'b00, 4'd0, 1'b0, 2'b00);
        step();
        check("t3_g0_again", 2'b01, 4'd2, 1'b1, 2'b00);
        bus.req = 2'b00;
        step();
        check("t3_abort", 2'b00, 4'd0, 1'b0, 2'b00);

        // T4 pause at cnt=2 for 3 cycles, then pause at cnt=0
        bus.req   = 2'b10;
        bus.load1 = 4'd4;
        step();
        check("t4_grant", 2'b10, 4'd4, 1'b1, 2'b00);
        step();
        check("t4_c3", 2'b10, 4'd3, 1'b1, 2'b00);
        step();
        check("t4_c2", 2'b10, 4'd2, 1'b1, 2'b00);
        bus.pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_hold", 2'b10, 4'd2, 1'b1, 2'b00);
        end
        bus.pause = 1'b0;
        step();
        check("t4_c1", 2'b10, 4'd1, 1'b1, 2'b00);
        step();
        check("t4_c0", 2'b10, 4'd0, 1'b1, 2'b00);
        bus.pause = 1'b1;
        step();
        check("t4_done_paused", 2'b10, 4'd0, 1'b1, 2'b10);
        bus.pause = 1'b0;
        bus.req   = 2'b00;
        step();
        check("t4_idle", 2'b00, 4'd0, 1'b0, 2'b00);

        // T5 abort at cnt=3
        bus.req   = 2'b01;
        bus.load0 = 4'd5;
        step();
        check("t5_grant", 2'b01, 4'd5, 1'b1, 2'b00);
        step();
        step();
        check("t5_c3", 2'b01, 4'd3, 1'b1, 2'b00);
        bus.req = 2'b00;
        step();
        check("t5_abort", 2'b00, 4'd0, 1'b0, 2'b00);
        step();
        check("t5_abort_nodone", 2'b00, 4'd0, 1'b0, 2'b00);

        // T5 start value 0
        bus.req   = 2'b01;
        bus.load0 = 4'd0;
        step();
        check("t5_z_grant", 2'b01, 4'd0, 1'b1, 2'b00);
        step();
        check("t5_z_done", 2'b01, 4'd0, 1'b1, 2'b01);
        bus.req = 2'b00;
        step();
        check("t5_z_idle", 2'b00, 4'd0, 1'b0, 2'b00);

        // T5 start value 15, no wrap; load and non-granted req changes ignored
        bus.req   = 2'b01;
        bus.load0 = 4'd15;
        step();
        check("t5_f_grant", 2'b01, 4'd15, 1'b1, 2'b00);
        bus.load0 = 4'd3;
        bus.req   = 2'b11;
        for (int k = 14; k >= 0; k--) begin
            step();
            check("t5_f_count", 2'b01, 4'(k), 1'b1, 2'b00);
        end
        bus.req = 2'b01;
        step();
        check("t5_f_done", 2'b01, 4'd0, 1'b1, 2'b01);
        bus.req = 2'b00;
        step();
        check("t5_f_idle", 2'b00, 4'd0, 1'b0, 2'b00);

        // T6 reset mid-run; pointer returns so req0 wins after reset
        bus.req   = 2'b01;
        bus.load0 = 4'd9;
        step();
        check("t6_grant", 2'b01, 4'd9, 1'b1, 2'b00);
        step();
        step();
        step();
        check("t6_c6", 2'b01, 4'd6, 1'b1, 2'b00);
        rst     = 1'b1;
        bus.req = 2'b11;
        step();
        check("t6_reset", 2'b00, 4'd0, 1'b0, 2'b00);
        rst = 1'b0;
        step();
        check("t6_regrant", 2'b01, 4'd9, 1'b1, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
